// File: rtl/sync_reg.sv
// Single-register CDC: samples a slow producer strobe, qualifier and word into r_clk
// and captures the word on each qualified falling edge of the synchronized strobe.
module sync_reg #(
  parameter int unsigned SIZE        = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            r_clk,
  input  logic            rst,
  input  logic            w_clk,
  input  logic            w_en,
  input  logic [SIZE-1:0] w_data,
  output logic [SIZE-1:0] r_data,
  output logic            r_empty
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] en_sync_q;
  logic [SIZE-1:0]        data_sync_q [SYNC_STAGES];
  logic                   clk_hist_q;

  logic [SIZE-1:0]        r_data_q, r_data_d;
  logic                   r_empty_q, r_empty_d;
  logic                   wr_event;
  logic                   wr_qual;

  // Chains reset to 0 so a strobe held high at release reads as a rise, never a fall.
  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= '0;
      en_sync_q  <= '0;
      clk_hist_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        data_sync_q[i] <= '0;
      end
    end else begin
      clk_sync_q     <= {clk_sync_q[SYNC_STAGES-2:0], w_clk};
      en_sync_q      <= {en_sync_q[SYNC_STAGES-2:0], w_en};
      clk_hist_q     <= clk_sync_q[SYNC_STAGES-1];
      data_sync_q[0] <= w_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        data_sync_q[i] <= data_sync_q[i-1];
      end
    end
  end

  always_comb begin
    wr_event = clk_hist_q & ~clk_sync_q[SYNC_STAGES-1];
    wr_qual  = wr_event & en_sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    r_data_d  = r_data_q;
    r_empty_d = r_empty_q;
    if (wr_qual) begin
      r_data_d  = data_sync_q[SYNC_STAGES-1];
      r_empty_d = 1'b0;
    end
  end

  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      r_data_q  <= '0;
      r_empty_q <= 1'b1;
    end else begin
      r_data_q  <= r_data_d;
      r_empty_q <= r_empty_d;
    end
  end

  assign r_data  = r_data_q;
  assign r_empty = r_empty_q;

endmodule

// File: tb/tb_sync_reg.sv
// Bench for sync_reg: table of strobe cycles with a queue of expected captures,
// plus hand-written reset-mid-operation and edge-during-reset sequences.
module tb_sync_reg;

  localparam int HALF = 5859;  // w_clk half period

  logic       r_clk;
  logic       rst;
  logic       w_clk;
  logic       w_en;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       r_empty;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       en;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic       exp_empty;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       empty;
  } exp_t;

  vec_t vecs [7];
  exp_t sb_q [$];
  exp_t cur;

  sync_reg #(
    .SIZE        (8),
    .SYNC_STAGES (2)
  ) dut (
    .r_clk   (r_clk),
    .rst     (rst),
    .w_clk   (w_clk),
    .w_en    (w_en),
    .w_data  (w_data),
    .r_data  (r_data),
    .r_empty (r_empty)
  );

  // Offset by 1 so r_clk rising edges (t = 4 mod 6) never coincide with w_clk/rst changes.
  initial begin
    r_clk = 1'b0;
    #1;
    forever #3 r_clk = ~r_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string name, input logic [7:0] ed, input logic ee);
    n_vec++;
    if (r_data !== ed || r_empty !== ee) begin
      n_err++;
      $display("FAIL %s: got r_data=%h r_empty=%b, want r_data=%h r_empty=%b",
               name, r_data, r_empty, ed, ee);
    end
  endtask

  task automatic drive_rise(input logic en, input logic [7:0] data,
                            input logic [7:0] ed, input logic ee);
    exp_t e;
    w_clk  = 1'b1;
    w_en   = en;
    w_data = data;
    e.data  = ed;
    e.empty = ee;
    sb_q.push_back(e);
  endtask

  // Falling edge, then: old value after 2 r_clk edges, new value by the 4th edge.
  task automatic fall_and_check(input string name);
    w_clk = 1'b0;
    fork
      #HALF;
      begin
        exp_t e;
        repeat (2) @(posedge r_clk);
        @(negedge r_clk);
        cmp({name, "_hold"}, cur.data, cur.empty);
        repeat (2) @(posedge r_clk);
        @(negedge r_clk);
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL %s: got empty scoreboard, want an expected entry", name);
        end else begin
          e = sb_q.pop_front();
          cmp({name, "_new"}, e.data, e.empty);
          cur = e;
        end
      end
    join
  endtask

  initial begin
    vecs[0] = '{en: 1'b1, data: 8'hBB, exp_data: 8'hBB, exp_empty: 1'b0};
    vecs[1] = '{en: 1'b0, data: 8'h55, exp_data: 8'hBB, exp_empty: 1'b0};
    vecs[2] = '{en: 1'b1, data: 8'h12, exp_data: 8'h12, exp_empty: 1'b0};
    vecs[3] = '{en: 1'b1, data: 8'h34, exp_data: 8'h34, exp_empty: 1'b0};
    vecs[4] = '{en: 1'b1, data: 8'hC3, exp_data: 8'hC3, exp_empty: 1'b0};
    vecs[5] = '{en: 1'b0, data: 8'h3C, exp_data: 8'hC3, exp_empty: 1'b0};
    vecs[6] = '{en: 1'b1, data: 8'h00, exp_data: 8'h00, exp_empty: 1'b0};

    // Reset hold: strobe toggles with a qualified 0xFF word while rst is high.
    rst    = 1'b1;
    w_clk  = 1'b1;
    w_en   = 1'b1;
    w_data = 8'hFF;
    cur.data  = 8'h00;
    cur.empty = 1'b1;
    #2;
    cmp("reset_t0", 8'h00, 1'b1);
    #(HALF - 2) w_clk = 1'b0;
    #100 cmp("reset_fall1", 8'h00, 1'b1);
    #(HALF - 100) w_clk = 1'b1;
    #100 cmp("reset_rise", 8'h00, 1'b1);
    #(HALF - 100) w_clk = 1'b0;
    #100 cmp("reset_fall2", 8'h00, 1'b1);
    #(20000 - 3 * HALF - 100) rst = 1'b0;  // t = 20000
    #(4 * HALF - 20000) cmp("post_release", 8'h00, 1'b1);  // t = 23436

    // Basic write, unqualified edge, back-to-back.
    for (int i = 0; i < 4; i++) begin
      drive_rise(vecs[i].en, vecs[i].data, vecs[i].exp_data, vecs[i].exp_empty);
      #HALF;
      fall_and_check($sformatf("vec%0d", i));
    end

    // Reset mid-operation, released while w_clk is high.
    drive_rise(1'b1, 8'h77, 8'h77, 1'b0);
    @(posedge r_clk);
    #2 rst = 1'b1;
    #1 cmp("mid_reset_immediate", 8'h00, 1'b1);
    cur.data  = 8'h00;
    cur.empty = 1'b1;
    #100 rst = 1'b0;
    #(HALF - 103) cmp("mid_release_high", 8'h00, 1'b1);
    #HALF cmp("mid_still_empty", 8'h00, 1'b1);
    fall_and_check("mid_next_edge");

    // Edge during reset: falling edge with qualified 0xA5 is lost.
    w_clk  = 1'b1;
    w_en   = 1'b1;
    w_data = 8'hA5;
    #HALF rst = 1'b1;
    #1 cmp("edge_rst_assert", 8'h00, 1'b1);
    cur.data  = 8'h00;
    cur.empty = 1'b1;
    #100 w_clk = 1'b0;
    #100 rst = 1'b0;
    #(HALF - 201) cmp("edge_rst_lost", 8'h00, 1'b1);

    for (int i = 4; i < 7; i++) begin
      drive_rise(vecs[i].en, vecs[i].data, vecs[i].exp_data, vecs[i].exp_empty);
      #HALF;
      fall_and_check($sformatf("vec%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
